// File: rtl/hash_result_checker.sv
// Scans the four lane digests of one double-hash result against a difficulty
// target and queues every golden nonce in a small FIFO for the consumer.
module hash_result_checker #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         digest_valid,
  input  logic [31:0]  base_nonce,
  input  logic [255:0] lane_top,
  input  logic [63:0]  target,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_nonce,
  output logic [1:0]   out_lane,
  output logic         busy,
  output logic         overflow,
  output logic         dropped,
  input  logic         clr_flags,
  output logic [15:0]  hit_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [1:0]  lane;
  } entry_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_accept;

  logic [1:0]     r_lane;
  logic [255:0]   r_tops;
  logic [63:0]    r_target;
  logic [31:0]    r_base;
  logic [63:0]    w_lane_top;

  logic           w_hit;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic           w_wr_en;
  logic           w_ovf_set;
  logic           w_drop_set;

  entry_t         r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  logic           r_overflow;
  logic           r_dropped;
  logic [15:0]    r_hit_count;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (digest_valid) begin
          w_state_nxt = S_SCAN;
          w_accept    = 1'b1;
        end
      end
      S_SCAN: begin
        if (r_lane == 2'd3) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (r_state == S_SCAN);
  assign w_drop_set = digest_valid && busy;

  // ---------------------------------------------------------------------------
  // Latched digest and lane scan
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane   <= 2'd0;
      r_tops   <= '0;
      r_target <= '0;
      r_base   <= '0;
    end else if (w_accept) begin
      r_lane   <= 2'd0;
      r_tops   <= lane_top;
      r_target <= target;
      r_base   <= base_nonce;
    end else if (busy) begin
      r_lane   <= r_lane + 2'd1;
    end
  end

  always_comb begin
    w_lane_top = r_tops[63:0];
    case (r_lane)
      2'd0: w_lane_top = r_tops[63:0];
      2'd1: w_lane_top = r_tops[127:64];
      2'd2: w_lane_top = r_tops[191:128];
      2'd3: w_lane_top = r_tops[255:192];
      default: w_lane_top = r_tops[63:0];
    endcase
  end

  // Equality with the target is deliberately not a hit.
  assign w_hit = busy && (w_lane_top < r_target);

  // ---------------------------------------------------------------------------
  // Golden-nonce FIFO
  // ---------------------------------------------------------------------------
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = !w_empty && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_wr_en   = w_hit && (!w_full || w_pop);
  assign w_ovf_set = w_hit && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers/count and the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= '{nonce: r_base + {30'd0, r_lane}, lane: r_lane};
    end
  end

  assign out_valid = !w_empty;
  assign out_nonce = w_empty ? 32'd0 : r_mem[r_rd_ptr].nonce;
  assign out_lane  = w_empty ? 2'd0  : r_mem[r_rd_ptr].lane;

  // ---------------------------------------------------------------------------
  // Sticky flags and hit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_dropped   <= 1'b0;
      r_hit_count <= 16'd0;
    end else begin
      // A set condition in the same cycle as clr_flags leaves the flag set.
      r_overflow <= w_ovf_set  || (r_overflow && !clr_flags);
      r_dropped  <= w_drop_set || (r_dropped  && !clr_flags);
      if (w_hit && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign dropped   = r_dropped;
  assign hit_count = r_hit_count;

endmodule

// File: tb/tb_hash_result_checker.sv
// Self-checking bench for hash_result_checker: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_hash_result_checker;

  localparam int DEPTH = 4;

  logic         clk          = 1'b0;
  logic         rst_n        = 1'b1;
  logic         digest_valid = 1'b0;
  logic [31:0]  base_nonce   = '0;
  logic [255:0] lane_top     = '0;
  logic [63:0]  target       = '0;
  logic         out_ready    = 1'b0;
  logic         clr_flags    = 1'b0;
  logic         out_valid;
  logic [31:0]  out_nonce;
  logic [1:0]   out_lane;
  logic         busy;
  logic         overflow;
  logic         dropped;
  logic [15:0]  hit_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queued golden entries {nonce, lane}, lane evaluations
  // still pending {hit, nonce, lane}, hit total and sticky flags.
  logic [33:0] m_q[$];
  logic [34:0] m_pend[$];
  int          m_hits;
  bit          m_ovf;
  bit          m_drop;
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];

  hash_result_checker #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digest_valid (digest_valid),
    .base_nonce   (base_nonce),
    .lane_top     (lane_top),
    .target       (target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_nonce    (out_nonce),
    .out_lane     (out_lane),
    .busy         (busy),
    .overflow     (overflow),
    .dropped      (dropped),
    .clr_flags    (clr_flags),
    .hit_count    (hit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_q.delete();
    m_pend.delete();
    obs_q.delete();
    exp_q.delete();
    m_hits = 0;
    m_ovf  = 1'b0;
    m_drop = 1'b0;
  endtask

  // Advance one clock: record the observed pop, apply the model's rules for
  // this cycle, then return 1 time unit after the rising edge.
  task automatic step();
    logic [34:0] ev;
    logic        popped;
    if (out_valid && out_ready) obs_q.push_back({out_nonce, out_lane});
    popped = (m_q.size() != 0) && out_ready;
    if (popped) exp_q.push_back(m_q.pop_front());
    if (clr_flags) begin
      m_ovf  = 1'b0;
      m_drop = 1'b0;
    end
    if (m_pend.size() != 0) begin
      ev = m_pend.pop_front();
      if (digest_valid) m_drop = 1'b1;
      if (ev[34]) begin
        if (m_hits < 65535) m_hits++;
        if (m_q.size() < DEPTH) m_q.push_back(ev[33:0]);
        else m_ovf = 1'b1;
      end
    end else if (digest_valid) begin
      for (int k = 0; k < 4; k++) begin
        m_pend.push_back({lane_top[64*k +: 64] < target, base_nonce + 32'(k), 2'(k)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    digest_valid = 1'b0;
    out_ready    = 1'b0;
    clr_flags    = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    digest_valid = 1'b0;
    clr_flags    = 1'b0;
    out_ready    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (m_q.size() == 0 && m_pend.size() == 0 && !out_valid) break;
      step();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_nonce !== 32'd0) $display("FAIL reset_out_nonce: got %h want 0", out_nonce); else n_pass++;
    n_total++; if (out_lane !== 2'd0) $display("FAIL reset_out_lane: got %h want 0", out_lane); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL reset_dropped: got %b want 0", dropped); else n_pass++;
    n_total++; if (hit_count !== 16'd0) $display("FAIL reset_hit_count: got %h want 0", hit_count); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_hits();
    logic [33:0] want [2];
    want[0] = {32'h0000_0100, 2'd0};
    want[1] = {32'h0000_0102, 2'd2};
    do_reset();
    out_ready    = 1'b1;
    base_nonce   = 32'h100;
    target       = 64'h0000_0001_0000_0000;
    lane_top     = {64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    repeat (6) step();
    n_total++; if (obs_q.size() != 2) $display("FAIL basic_count: got %0d want 2", obs_q.size()); else n_pass++;
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== want[i]) $display("FAIL basic_entry%0d: got %h want %h", i, obs_q[i], want[i]); else n_pass++;
    end
    n_total++; if (hit_count !== 16'd2) $display("FAIL basic_hit_count: got %0d want 2", hit_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_nonce_wrap();
    logic [31:0] want [4];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF;
    want[2] = 32'h0000_0000; want[3] = 32'h0000_0001;
    do_reset();
    base_nonce   = 32'hFFFF_FFFE;
    target       = 64'h10;
    lane_top     = '0;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    repeat (4) step();
    drain();
    n_total++; if (obs_q.size() != 4) $display("FAIL wrap_count: got %0d want 4", obs_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== {want[i], 2'(i)}) $display("FAIL wrap_entry%0d: got %h want %h", i, obs_q[i], {want[i], 2'(i)}); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    target       = 64'hFFFF_FFFF_FFFF_FFFF;
    lane_top     = {4{64'h1234}};
    base_nonce   = 32'h1000;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    repeat (5) step();
    base_nonce   = 32'h2000;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    repeat (5) step();
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    n_total++; if (hit_count !== 16'd8) $display("FAIL ovf_hit_count: got %0d want 8", hit_count); else n_pass++;
    n_total++; if (out_nonce !== 32'h1000) $display("FAIL ovf_head: got %h want 00001000", out_nonce); else n_pass++;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
    drain();
    n_total++; if (obs_q.size() != 4) $display("FAIL ovf_count: got %0d want 4", obs_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== {32'h1000 + 32'(i), 2'(i)}) $display("FAIL ovf_entry%0d: got %h want %h", i, obs_q[i], {32'h1000 + 32'(i), 2'(i)}); else n_pass++;
    end
  endtask

  task automatic test_dropped();
    do_reset();
    out_ready    = 1'b1;
    target       = 64'h8000_0000_0000_0000;
    lane_top     = {1'b0, 31'($urandom), 32'($urandom), 1'b0, 31'($urandom), 32'($urandom),
                    1'b0, 31'($urandom), 32'($urandom), 1'b0, 31'($urandom), 32'($urandom)};
    base_nonce   = 32'h3000;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    step();
    base_nonce   = 32'h4000;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    n_total++; if (dropped !== 1'b1) $display("FAIL drop_flag: got %b want 1", dropped); else n_pass++;
    clr_flags    = 1'b1;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    n_total++; if (dropped !== 1'b1) $display("FAIL drop_set_wins: got %b want 1", dropped); else n_pass++;
    step();
    clr_flags = 1'b0;
    n_total++; if (dropped !== 1'b0) $display("FAIL drop_clear: got %b want 0", dropped); else n_pass++;
    drain();
    n_total++; if (obs_q.size() != 4) $display("FAIL drop_count: got %0d want 4", obs_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_total++; if (obs_q[i] !== {32'h3000 + 32'(i), 2'(i)}) $display("FAIL drop_entry%0d: got %h want %h", i, obs_q[i], {32'h3000 + 32'(i), 2'(i)}); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    target       = 64'hFFFF_FFFF_FFFF_FFFF;
    lane_top     = '0;
    base_nonce   = 32'h5000;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    repeat (4) step();
    base_nonce   = 32'h6000;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    out_ready    = 1'b1;
    repeat (4) step();
    n_total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", overflow); else n_pass++;
    n_total++; if (obs_q.size() != 4) $display("FAIL b2b_popped: got %0d want 4", obs_q.size()); else n_pass++;
    n_total++; if (out_nonce !== 32'h6000) $display("FAIL b2b_head: got %h want 00006000", out_nonce); else n_pass++;
    drain();
    n_total++; if (obs_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", obs_q.size()); else n_pass++;
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      logic [31:0] nb;
      nb = (i < 4) ? 32'h5000 : 32'h6000;
      n_total++; if (obs_q[i] !== {nb + 32'(i % 4), 2'(i % 4)}) $display("FAIL b2b_entry%0d: got %h want %h", i, obs_q[i], {nb + 32'(i % 4), 2'(i % 4)}); else n_pass++;
    end
    n_total++; if (hit_count !== 16'd8) $display("FAIL b2b_hit_count: got %0d want 8", hit_count); else n_pass++;
  endtask

  task automatic test_reset_midscan();
    do_reset();
    target       = 64'hFFFF_FFFF_FFFF_FFFF;
    lane_top     = '0;
    base_nonce   = 32'h7000;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL midscan_pre_valid: got %b want 1", out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midscan_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midscan_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (hit_count !== 16'd0) $display("FAIL midscan_hit_count: got %0d want 0", hit_count); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready    = 1'b1;
    target       = 64'h100;
    lane_top     = {64'h100, 64'h200, 64'hFF, 64'h101};
    base_nonce   = 32'h7100;
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
    repeat (6) step();
    n_total++; if (obs_q.size() != 1) $display("FAIL midscan_count: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() != 0) begin
      n_total++; if (obs_q[0] !== {32'h7101, 2'd1}) $display("FAIL midscan_entry: got %h want %h", obs_q[0], {32'h7101, 2'd1}); else n_pass++;
    end
    n_total++; if (hit_count !== 16'd1) $display("FAIL midscan_hits_after: got %0d want 1", hit_count); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      digest_valid = ($urandom_range(0, 2) == 0);
      base_nonce   = $urandom;
      target       = {$urandom, $urandom};
      lane_top     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      out_ready    = ($urandom_range(0, 3) == 0);
      clr_flags    = ($urandom_range(0, 15) == 0);
      step();
      n_total++; if (busy !== (m_pend.size() != 0)) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_pend.size() != 0); else n_pass++;
      n_total++; if (out_valid !== (m_q.size() != 0)) $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, m_q.size() != 0); else n_pass++;
      n_total++; if (overflow !== m_ovf) $display("FAIL rnd_overflow c%0d: got %b want %b", c, overflow, m_ovf); else n_pass++;
      n_total++; if (dropped !== m_drop) $display("FAIL rnd_dropped c%0d: got %b want %b", c, dropped, m_drop); else n_pass++;
      n_total++; if (hit_count !== 16'(m_hits)) $display("FAIL rnd_hit_count c%0d: got %0d want %0d", c, hit_count, m_hits); else n_pass++;
      if (m_q.size() != 0) begin
        n_total++; if ({out_nonce, out_lane} !== m_q[0]) $display("FAIL rnd_head c%0d: got %h want %h", c, {out_nonce, out_lane}, m_q[0]); else n_pass++;
      end
    end
    drain();
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_pop_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        n_total++;
        $display("FAIL rnd_pop%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hits();
    test_nonce_wrap();
    test_overflow();
    test_dropped();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
